// File: rtl/k16_bus_fabric.sv
// rtl/k16_bus_fabric.sv - K16 CPU-to-slave bus fabric: address decode, wait states, error response
module k16_bus_fabric #(
    parameter int NUM_SLAVES = 4,
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_BASE = {16'hFFF8, 16'hF000, 16'h8000, 16'h0000},
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_MASK = {16'hFFF8, 16'hFE00, 16'hF800, 16'hF000},
    parameter logic [NUM_SLAVES*4-1:0]      SLAVE_WAIT = {4'd2, 4'd1, 4'd1, 4'd1},
    parameter logic [NUM_SLAVES-1:0]        SLAVE_RO   = 4'b0100,
    parameter logic [DATA_W-1:0]            UNMAPPED_DATA = 16'h9FFF
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         cpu_req,
    input  logic [ADDR_W-1:0]            cpu_addr,
    input  logic [DATA_W-1:0]            cpu_dout,
    input  logic                         cpu_write,
    input  logic                         hold,
    output logic [DATA_W-1:0]            cpu_din,
    output logic                         cpu_ready,
    output logic                         bus_error,
    output logic [NUM_SLAVES-1:0]        s_sel,
    output logic [NUM_SLAVES-1:0]        s_write,
    output logic [ADDR_W-1:0]            s_addr,
    output logic [DATA_W-1:0]            s_wdata,
    input  logic [NUM_SLAVES*DATA_W-1:0] s_rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [NUM_SLAVES-1:0]   sel_q, sel_d;
    logic [NUM_SLAVES-1:0]   wr_q, wr_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic [DATA_W-1:0]       wdata_q, wdata_d;
    logic [DATA_W-1:0]       din_q, din_d;
    logic                    ready_q, ready_d;
    logic                    err_q, err_d;
    logic                    hit_q, hit_d;
    logic                    is_write_q, is_write_d;
    logic                    ro_q, ro_d;

    logic                    dec_hit;
    logic                    dec_ro;
    logic [3:0]              dec_wait;
    logic [NUM_SLAVES-1:0]   dec_sel;
    logic [DATA_W-1:0]       rdata_sel;

    // Scan from the top index down so the lowest matching slave overrides.
    always_comb begin
        dec_hit  = 1'b0;
        dec_ro   = 1'b0;
        dec_wait = 4'd0;
        dec_sel  = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if ((cpu_addr & SLAVE_MASK[i*ADDR_W +: ADDR_W]) == SLAVE_BASE[i*ADDR_W +: ADDR_W]) begin
                dec_hit    = 1'b1;
                dec_ro     = SLAVE_RO[i];
                dec_wait   = SLAVE_WAIT[i*4 +: 4];
                dec_sel    = '0;
                dec_sel[i] = 1'b1;
            end
        end
    end

    always_comb begin
        rdata_sel = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (sel_q[i]) rdata_sel = s_rdata[i*DATA_W +: DATA_W];
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sel_d      = sel_q;
        wr_d       = '0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        din_d      = din_q;
        ready_d    = 1'b0;
        err_d      = 1'b0;
        hit_d      = hit_q;
        is_write_d = is_write_q;
        ro_d       = ro_q;
        case (state_q)
            IDLE: begin
                if (cpu_req && !hold) begin
                    addr_d     = cpu_addr;
                    wdata_d    = cpu_dout;
                    sel_d      = dec_sel;
                    wr_d       = (cpu_write && !dec_ro) ? dec_sel : '0;
                    cnt_d      = dec_wait;
                    hit_d      = dec_hit;
                    is_write_d = cpu_write;
                    ro_d       = dec_ro;
                    state_d    = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_q == 4'd0) begin
                    if (!is_write_q) din_d = hit_q ? rdata_sel : UNMAPPED_DATA;
                    sel_d   = '0;
                    ready_d = 1'b1;
                    err_d   = !hit_q || (is_write_q && ro_q);
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            sel_q      <= '0;
            wr_q       <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            din_q      <= '0;
            ready_q    <= 1'b0;
            err_q      <= 1'b0;
            hit_q      <= 1'b0;
            is_write_q <= 1'b0;
            ro_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sel_q      <= sel_d;
            wr_q       <= wr_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            din_q      <= din_d;
            ready_q    <= ready_d;
            err_q      <= err_d;
            hit_q      <= hit_d;
            is_write_q <= is_write_d;
            ro_q       <= ro_d;
        end
    end

    assign cpu_din   = din_q;
    assign cpu_ready = ready_q;
    assign bus_error = err_q;
    assign s_sel     = sel_q;
    assign s_write   = wr_q;
    assign s_addr    = addr_q;
    assign s_wdata   = wdata_q;

endmodule

// File: tb/tb_k16_bus_fabric.sv
// tb/tb_k16_bus_fabric.sv - self-checking bench for k16_bus_fabric with a table-driven memory-map model
module tb_k16_bus_fabric;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req;
    logic [15:0] cpu_addr;
    logic [15:0] cpu_dout;
    logic        cpu_write;
    logic        hold;
    logic [15:0] cpu_din;
    logic        cpu_ready;
    logic        bus_error;
    logic [3:0]  s_sel;
    logic [3:0]  s_write;
    logic [15:0] s_addr;
    logic [15:0] s_wdata;
    logic [63:0] s_rdata;

    int checks = 0;
    int errors = 0;

    // Memory map as the CPU sees it.
    int base_t [4] = '{32'h0000, 32'h8000, 32'hF000, 32'hFFF8};
    int mask_t [4] = '{32'hF000, 32'hF800, 32'hFE00, 32'hFFF8};
    int wait_t [4] = '{1, 1, 1, 2};
    int ro_t   [4] = '{0, 0, 1, 0};

    logic [15:0] exp_din;

    k16_bus_fabric dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_req   (cpu_req),
        .cpu_addr  (cpu_addr),
        .cpu_dout  (cpu_dout),
        .cpu_write (cpu_write),
        .hold      (hold),
        .cpu_din   (cpu_din),
        .cpu_ready (cpu_ready),
        .bus_error (bus_error),
        .s_sel     (s_sel),
        .s_write   (s_write),
        .s_addr    (s_addr),
        .s_wdata   (s_wdata),
        .s_rdata   (s_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic int decode(input logic [15:0] a);
        for (int i = 0; i < 4; i++) begin
            if ((int'(a) & mask_t[i]) == base_t[i]) return i;
        end
        return -1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One complete transfer, checked cycle by cycle against the memory map model.
    task automatic xfer(input logic [15:0] a, input logic [15:0] d, input logic wr,
                        input logic [63:0] rd, input int hold_cycles, input bit hold_mid);
        int          idx;
        int          lat;
        logic        e_err;
        logic [3:0]  onehot;
        idx    = decode(a);
        lat    = (idx < 0) ? 2 : 2 + wait_t[idx];
        onehot = (idx < 0) ? 4'b0000 : 4'(1 << idx);
        e_err  = (idx < 0) || (wr && ro_t[idx] != 0);
        if (!wr) exp_din = (idx < 0) ? 16'h9FFF : rd[idx*16 +: 16];
        s_rdata   = rd;
        cpu_addr  = a;
        cpu_dout  = d;
        cpu_write = wr;
        cpu_req   = 1'b1;
        for (int k = 0; k < hold_cycles; k++) begin
            hold = 1'b1;
            step();
            check("hold_sel", s_sel, 4'b0000);
            check("hold_ready", cpu_ready, 1'b0);
        end
        hold = 1'b0;
        for (int c = 1; c <= lat; c++) begin
            step();
            cpu_req = 1'b0;
            if (hold_mid) hold = 1'b1;
            check("s_sel", s_sel, (c < lat) ? onehot : 4'b0000);
            check("s_write", s_write, (c == 1 && wr && idx >= 0 && ro_t[idx] == 0) ? onehot : 4'b0000);
            check("cpu_ready", cpu_ready, c == lat);
            check("bus_error", bus_error, (c == lat) ? e_err : 1'b0);
            if (c == 1) begin
                check("s_addr", s_addr, a);
                check("s_wdata", s_wdata, d);
            end
            if (c == lat) check("cpu_din", cpu_din, exp_din);
        end
        step();
        hold = 1'b0;
        check("idle_ready", cpu_ready, 1'b0);
        check("idle_error", bus_error, 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_sel"}, s_sel, 4'b0000);
        check({tag, "_write"}, s_write, 4'b0000);
        check({tag, "_addr"}, s_addr, 16'h0000);
        check({tag, "_wdata"}, s_wdata, 16'h0000);
        check({tag, "_din"}, cpu_din, 16'h0000);
        check({tag, "_ready"}, cpu_ready, 1'b0);
        check({tag, "_error"}, bus_error, 1'b0);
    endtask

    function automatic logic [15:0] rand_addr();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 4))
            0:       return {4'h0, r[11:0]};
            1:       return {5'b10000, r[10:0]};
            2:       return {7'b1111000, r[8:0]};
            3:       return {13'h1FFF, r[2:0]};
            default: return r[15:0];
        endcase
    endfunction

    initial begin
        logic [63:0] rd;
        reset     = 1'b1;
        cpu_req   = 1'b0;
        cpu_addr  = '0;
        cpu_dout  = '0;
        cpu_write = 1'b0;
        hold      = 1'b0;
        s_rdata   = '0;
        exp_din   = '0;
        step();
        step();
        step();
        check_reset_outputs("reset");
        reset = 1'b0;
        step();

        rd = {16'h3333, 16'h2222, 16'h1111, 16'hBEEF};
        xfer(16'h0123, 16'h0000, 1'b0, rd, 0, 1'b0);
        xfer(16'hFFF9, 16'h1234, 1'b1, rd, 0, 1'b0);
        xfer(16'h4000, 16'h0000, 1'b0, rd, 0, 1'b0);
        xfer(16'hF010, 16'h5A5A, 1'b1, rd, 0, 1'b0);
        xfer(16'hF010, 16'h0000, 1'b0, rd, 0, 1'b0);
        xfer(16'h8004, 16'h0000, 1'b0, rd, 5, 1'b1);
        xfer(16'hFFFF, 16'h0000, 1'b0, rd, 0, 1'b1);

        // Reset in the first ACCESS cycle of a read aborts it cleanly.
        cpu_addr  = 16'h0010;
        cpu_write = 1'b0;
        cpu_req   = 1'b1;
        step();
        cpu_req = 1'b0;
        check("abort_sel_c1", s_sel, 4'b0001);
        reset = 1'b1;
        step();
        reset   = 1'b0;
        exp_din = 16'h0000;
        check_reset_outputs("abort");
        step();
        check("abort_no_ready", cpu_ready, 1'b0);
        check("abort_no_error", bus_error, 1'b0);
        check("abort_no_sel", s_sel, 4'b0000);
        xfer(16'h0010, 16'h0000, 1'b0, rd, 0, 1'b0);

        for (int n = 0; n < 60; n++) begin
            rd = {$urandom, $urandom};
            xfer(rand_addr(), 16'($urandom), 1'($urandom), rd, $urandom_range(0, 2), 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
